// File: rtl/dm_lsu.sv
// Byte-addressed data memory for the load/store path: one word RAM inside a base-address
// window, byte/half/word accesses, extended loads and a single registered response per request.
module dm_lsu #(
    parameter logic [31:0] BASE_ADDR  = 32'h7100_0000,
    parameter int          DEPTH_LOG2 = 6,
    parameter int          ERRCNT_W   = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [1:0]          size_i,
    input  logic                unsigned_i,
    input  logic [31:0]         a_i,
    input  logic [31:0]         wd_i,
    output logic [31:0]         rd_o,
    output logic                valid_o,
    output logic                err_o,
    output logic [ERRCNT_W-1:0] err_cnt_o
);

    localparam int DEPTH   = 1 << DEPTH_LOG2;
    localparam int TAG_LSB = DEPTH_LOG2 + 2;

    // Handshake: no back-pressure. Every cycle with req_i=1 is accepted and produces exactly
    // one response with valid_o=1 in the following cycle; rd_o/err_o are zero when valid_o=0.

    logic [31:0]           mem [DEPTH];
    logic                  in_range;
    logic [DEPTH_LOG2-1:0] idx;
    logic [1:0]            off;
    logic                  acc_err;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [31:0]           rword;
    logic [31:0]           shifted;
    logic [31:0]           ld_data;

    always_comb begin
        in_range = (a_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
        idx      = a_i[TAG_LSB-1:2];
        off      = a_i[1:0];
        acc_err  = !in_range || (size_i == 2'b11) ||
                   ((size_i == 2'b01) && off[0]) ||
                   ((size_i == 2'b10) && (off != 2'b00));
    end

    // Store data is replicated across lanes so the lane mask alone selects what lands.
    always_comb begin
        be    = 4'b1111;
        wdata = wd_i;
        case (size_i)
            2'b00: begin
                be    = 4'b0001 << off;
                wdata = {4{wd_i[7:0]}};
            end
            2'b01: begin
                be    = 4'b0011 << off;
                wdata = {2{wd_i[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = wd_i;
            end
        endcase
    end

    always_comb begin
        rword   = mem[idx];
        shifted = rword >> {off, 3'b000};
        ld_data = rword;
        case (size_i)
            2'b00:   ld_data = unsigned_i ? {24'h0, shifted[7:0]}
                                          : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ld_data = unsigned_i ? {16'h0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            default: ld_data = rword;
        endcase
    end

    // RAM has no reset; stores are simply suppressed while reset is held.
    always_ff @(posedge clk_i) begin
        if (!rst_i && req_i && we_i && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_o      <= '0;
            valid_o   <= 1'b0;
            err_o     <= 1'b0;
            err_cnt_o <= '0;
        end else begin
            valid_o <= req_i;
            err_o   <= req_i && acc_err;
            rd_o    <= (req_i && !we_i && !acc_err) ? ld_data : 32'h0;
            if (req_i && acc_err && (err_cnt_o != '1)) begin
                err_cnt_o <= err_cnt_o + ERRCNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_dm_lsu.sv
// Bench for dm_lsu: directed scenarios plus random traffic checked against a byte-array model.
module tb_dm_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'b00;
    logic        unsigned_i = 1'b0;
    logic [31:0] a_i = 32'h0;
    logic [31:0] wd_i = 32'h0;
    logic [31:0] rd_o;
    logic        valid_o;
    logic        err_o;
    logic [7:0]  err_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: flat byte array over the 256-byte window plus an error tally.
    logic [7:0] mem_b [256];
    int         cnt_m = 0;

    dm_lsu dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .a_i        (a_i),
        .wd_i       (wd_i),
        .rd_o       (rd_o),
        .valid_o    (valid_o),
        .err_o      (err_o),
        .err_cnt_o  (err_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
        logic bad;
        bad = (a[31:8] != 24'h710000) || (sz == 2'd3);
        if (sz == 2'd1 && (a % 2) != 0) bad = 1'b1;
        if (sz == 2'd2 && (a % 4) != 0) bad = 1'b1;
        return bad;
    endfunction

    task automatic do_req(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd, input string tag);
        logic        e;
        logic [31:0] rd_e;
        int          k;
        int          nbytes;
        e      = model_err(sz, a);
        rd_e   = 32'h0;
        k      = int'(a[7:0]);
        nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (e) begin
            if (cnt_m < 255) cnt_m++;
        end else if (we) begin
            for (int i = 0; i < nbytes; i++) mem_b[k+i] = wd[8*i +: 8];
        end else begin
            for (int i = 0; i < nbytes; i++) rd_e[8*i +: 8] = mem_b[k+i];
            if (nbytes == 1 && !uns && rd_e[7])  rd_e[31:8]  = 24'hFFFFFF;
            if (nbytes == 2 && !uns && rd_e[15]) rd_e[31:16] = 16'hFFFF;
        end
        @(negedge clk_i);
        req_i = 1'b1; we_i = we; size_i = sz; unsigned_i = uns; a_i = a; wd_i = wd;
        @(posedge clk_i);
        #1;
        check({tag, ".valid"}, 32'(valid_o), 32'd1);
        check({tag, ".err"}, 32'(err_o), 32'(e));
        check({tag, ".rd"}, rd_o, rd_e);
        check({tag, ".cnt"}, 32'(err_cnt_o), 32'(cnt_m));
    endtask

    task automatic idle(input string tag);
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
        @(posedge clk_i);
        #1;
        check({tag, ".valid"}, 32'(valid_o), 32'd0);
        check({tag, ".err"}, 32'(err_o), 32'd0);
        check({tag, ".rd"}, rd_o, 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        #1;
        check("rst.valid", 32'(valid_o), 32'd0);
        check("rst.err", 32'(err_o), 32'd0);
        check("rst.rd", rd_o, 32'd0);
        check("rst.cnt", 32'(err_cnt_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;

        // Fill the window so every model byte is defined.
        for (int w = 0; w < 64; w++) do_req(1'b1, 2'd2, 1'b0, 32'h7100_0000 + 32'(4*w), $urandom, "fill");
        idle("idle0");

        do_req(1'b1, 2'd2, 1'b0, 32'h7100_0004, 32'hDEADBEEF, "t1.sw");
        do_req(1'b0, 2'd2, 1'b0, 32'h7100_0004, 32'h0, "t1.lw");
        check("t1.data", rd_o, 32'hDEADBEEF);
        do_req(1'b1, 2'd0, 1'b0, 32'h7100_0005, 32'h55, "t2.sb");
        do_req(1'b0, 2'd2, 1'b0, 32'h7100_0004, 32'h0, "t2.lw");
        check("t2.data", rd_o, 32'hDEAD55EF);
        do_req(1'b0, 2'd0, 1'b0, 32'h7100_0007, 32'h0, "t2.lb");
        check("t2.lb_data", rd_o, 32'hFFFFFFDE);
        do_req(1'b0, 2'd0, 1'b1, 32'h7100_0007, 32'h0, "t2.lbu");
        check("t2.lbu_data", rd_o, 32'h000000DE);
        do_req(1'b1, 2'd1, 1'b0, 32'h7100_0006, 32'h8001, "t3.sh");
        do_req(1'b0, 2'd1, 1'b0, 32'h7100_0006, 32'h0, "t3.lh");
        check("t3.lh_data", rd_o, 32'hFFFF8001);
        do_req(1'b0, 2'd1, 1'b1, 32'h7100_0006, 32'h0, "t3.lhu");
        check("t3.lhu_data", rd_o, 32'h00008001);
        do_req(1'b0, 2'd2, 1'b0, 32'h7100_0004, 32'h0, "t3.lw");
        check("t3.lw_data", rd_o, 32'h800155EF);
        idle("idle1");

        do_req(1'b0, 2'd2, 1'b0, 32'h7100_0002, 32'h0, "t4.lw_mis");
        do_req(1'b1, 2'd1, 1'b0, 32'h7100_0003, 32'hFFFF, "t4.sh_mis");
        do_req(1'b0, 2'd3, 1'b0, 32'h7100_0004, 32'h0, "t4.sz11");
        do_req(1'b0, 2'd2, 1'b0, 32'h7100_0100, 32'h0, "t4.oor");
        check("t4.cnt4", 32'(err_cnt_o), 32'd4);
        do_req(1'b0, 2'd2, 1'b0, 32'h7100_0004, 32'h0, "t4.intact");
        check("t4.intact_data", rd_o, 32'h800155EF);
        for (int i = 0; i < 256; i++) do_req(1'b1, 2'd2, 1'b0, 32'h7200_0000, 32'h0, "t4.sat");
        check("t4.cnt_sat", 32'(err_cnt_o), 32'hFF);
        idle("idle2");

        do_req(1'b1, 2'd2, 1'b0, 32'h7100_0000, 32'h12345678, "t5.sw");
        do_req(1'b0, 2'd2, 1'b0, 32'h7100_0000, 32'h0, "t5.lw");
        check("t5.data", rd_o, 32'h12345678);

        // Reset with a load response in flight and a store held during reset.
        @(negedge clk_i);
        req_i = 1'b1; we_i = 1'b0; size_i = 2'd2; a_i = 32'h7100_0000;
        @(posedge clk_i);
        #1;
        check("t6.pending", 32'(valid_o), 32'd1);
        #2;
        rst_i = 1'b1;
        we_i = 1'b1; wd_i = 32'hFFFF_FFFF;
        #1;
        check("t6.drop_valid", 32'(valid_o), 32'd0);
        check("t6.drop_rd", rd_o, 32'd0);
        check("t6.cnt_clr", 32'(err_cnt_o), 32'd0);
        cnt_m = 0;
        @(negedge clk_i);
        req_i = 1'b0; we_i = 1'b0;
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("t6.no_resp", 32'(valid_o), 32'd0);
        do_req(1'b0, 2'd2, 1'b0, 32'h7100_0000, 32'h0, "t6.intact");
        check("t6.intact_data", rd_o, 32'h12345678);

        for (int i = 0; i < 600; i++) begin
            sz = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       a = $urandom;
                1:       a = 32'h7100_0100 + 32'($urandom_range(0, 255));
                default: a = {24'h710000, 8'($urandom)};
            endcase
            if ($urandom_range(0, 9) == 0) idle("rnd.idle");
            else do_req(1'($urandom), sz, 1'($urandom), a, $urandom, "rnd");
        end
        idle("idle_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
